shared_tlb_sv32: RTL and testbench

SHARED_TLB_SV32 -- requirements
Module: shared_tlb_sv32

---
 rtl/shared_tlb_sv32.sv | 246 ++++++++++++++++++++++++
 tb/tb_shared_tlb_sv32.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_tlb_sv32.sv
// ---------------------------------------------------------------------------
// shared_tlb_sv32
//
// Second-level, 8-entry fully associative Sv32 TLB shared by the instruction
// and data L1 TLBs. An L1 miss is accepted in IDLE, looked up one cycle
// later in LOOKUP, and the result is reported to the page-table walker. A
// hit also refills the requesting L1 TLB in that same cycle. The PTW fills
// entries here once a walk completes.
//
// Ports
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   flush_i                     invalidate every entry / abort a lookup
//   asid_i                      current address-space ID
//   itlb_access_i/itlb_vaddr_i  ITLB miss request + virtual address
//   dtlb_access_i/dtlb_vaddr_i  DTLB miss request + virtual address
//   itlb/dtlb_update_valid_o    refill pulse to the requesting L1 TLB
//   update_vpn/asid/is_4M/pte_o refill entry content (0 when no pulse)
//   shared_tlb_access_o         lookup-result pulse to the PTW
//   shared_tlb_hit_o            lookup hit
//   shared_tlb_vaddr_o          looked-up virtual address
//   itlb_req_o                  lookup originated from the ITLB
//   ptw_active_i                walk in progress (new requests are ignored)
//   ptw_update_*_i              PTW fill of one entry
// ---------------------------------------------------------------------------
module shared_tlb_sv32 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [8:0]  asid_i,
  input  logic        itlb_access_i,
  input  logic [31:0] itlb_vaddr_i,
  input  logic        dtlb_access_i,
  input  logic [31:0] dtlb_vaddr_i,
  output logic        itlb_update_valid_o,
  output logic        dtlb_update_valid_o,
  output logic [19:0] update_vpn_o,
  output logic [8:0]  update_asid_o,
  output logic        update_is_4M_o,
  output logic [31:0] update_pte_o,
  output logic        shared_tlb_access_o,
  output logic        shared_tlb_hit_o,
  output logic [31:0] shared_tlb_vaddr_o,
  output logic        itlb_req_o,
  input  logic        ptw_active_i,
  input  logic        ptw_update_valid_i,
  input  logic        ptw_update_is_4M_i,
  input  logic [19:0] ptw_update_vpn_i,
  input  logic [8:0]  ptw_update_asid_i,
  input  logic [31:0] ptw_update_pte_i
);

  localparam int unsigned NUM_ENTRIES = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOOKUP = 1'b1
  } state_e;

  typedef struct packed {
    logic        is_4m;
    logic [19:0] vpn;
    logic [8:0]  asid;
    logic [31:0] pte;
  } entry_t;

  state_e      state_q, state_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic        itlb_q, itlb_d;
  logic [8:0]  asid_q, asid_d;
  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  entry_t      entry_q [NUM_ENTRIES];
  entry_t      entry_d [NUM_ENTRIES];
  logic [2:0]  rr_q, rr_d;

  // -------------------------------------------------------------------------
  // Lookup against the request latched at acceptance. The entry array is
  // read as registered, so a fill in this same cycle is not seen until the
  // next one.
  // -------------------------------------------------------------------------
  logic [NUM_ENTRIES-1:0] lookup_match;
  logic                   lookup_hit;
  logic [2:0]             lookup_idx;

  always_comb begin
    lookup_match = '0;
    lookup_hit   = 1'b0;
    lookup_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      // pte[5] is the Sv32 G bit: a global mapping ignores the ASID.
      lookup_match[i] = valid_q[i]
                      && ((entry_q[i].asid == asid_q) || entry_q[i].pte[5])
                      && (entry_q[i].vpn[19:10] == vaddr_q[31:22])
                      && (entry_q[i].is_4m || (entry_q[i].vpn[9:0] == vaddr_q[21:12]));
    end
    // Ascending scan with a sticky flag: the lowest matching index wins.
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (lookup_match[i] && !lookup_hit) begin
        lookup_hit = 1'b1;
        lookup_idx = i[2:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Fill slot choice: an entry with the identical tag first (so that a
  // translation never exists twice), then the lowest free entry, and only
  // then the round-robin victim.
  // -------------------------------------------------------------------------
  logic       fill_tag_hit;
  logic       fill_free_hit;
  logic [2:0] fill_tag_idx;
  logic [2:0] fill_free_idx;
  logic [2:0] fill_idx;
  logic       fill_use_rr;

  always_comb begin
    fill_tag_hit  = 1'b0;
    fill_free_hit = 1'b0;
    fill_tag_idx  = '0;
    fill_free_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && !fill_tag_hit
          && (entry_q[i].vpn   == ptw_update_vpn_i)
          && (entry_q[i].asid  == ptw_update_asid_i)
          && (entry_q[i].is_4m == ptw_update_is_4M_i)) begin
        fill_tag_hit = 1'b1;
        fill_tag_idx = i[2:0];
      end
      if (!valid_q[i] && !fill_free_hit) begin
        fill_free_hit = 1'b1;
        fill_free_idx = i[2:0];
      end
    end
    fill_use_rr = !fill_tag_hit && !fill_free_hit;
    if (fill_tag_hit)       fill_idx = fill_tag_idx;
    else if (fill_free_hit) fill_idx = fill_free_idx;
    else                    fill_idx = rr_q;
  end

  // -------------------------------------------------------------------------
  // Next state: request acceptance, entry storage, victim pointer.
  // -------------------------------------------------------------------------
  logic accept;

  always_comb begin
    // NOTE: every always_comb target gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d = state_q;
    vaddr_d = vaddr_q;
    itlb_d  = itlb_q;
    asid_d  = asid_q;
    valid_d = valid_q;
    entry_d = entry_q;
    rr_d    = rr_q;

    accept = (state_q == IDLE) && (itlb_access_i || dtlb_access_i)
           && !ptw_active_i && !flush_i;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOOKUP;
          // The ITLB wins a tie; the DTLB request is dropped and re-issued.
          vaddr_d = itlb_access_i ? itlb_vaddr_i : dtlb_vaddr_i;
          itlb_d  = itlb_access_i;
          asid_d  = asid_i;
        end
      end
      LOOKUP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Flush overrides a simultaneous fill; the victim pointer is kept.
    if (flush_i) begin
      valid_d = '0;
    end else if (ptw_update_valid_i) begin
      valid_d[fill_idx]       = 1'b1;
      entry_d[fill_idx].is_4m = ptw_update_is_4M_i;
      entry_d[fill_idx].vpn   = ptw_update_vpn_i;
      entry_d[fill_idx].asid  = ptw_update_asid_i;
      entry_d[fill_idx].pte   = ptw_update_pte_i;
      if (fill_use_rr) rr_d = rr_q + 3'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from the LOOKUP state, so an asynchronous reset (state
  // back to IDLE) forces every output to 0 at once, and a flush in the
  // LOOKUP cycle suppresses them.
  // -------------------------------------------------------------------------
  logic lookup_fire;
  logic update_fire;

  always_comb begin
    lookup_fire = (state_q == LOOKUP) && !flush_i;
    update_fire = lookup_fire && lookup_hit;

    shared_tlb_access_o = lookup_fire;
    shared_tlb_hit_o    = update_fire;
    shared_tlb_vaddr_o  = lookup_fire ? vaddr_q : '0;
    itlb_req_o          = lookup_fire && itlb_q;

    itlb_update_valid_o = update_fire && itlb_q;
    dtlb_update_valid_o = update_fire && !itlb_q;
    update_vpn_o        = '0;
    update_asid_o       = '0;
    update_is_4M_o      = 1'b0;
    update_pte_o        = '0;
    if (update_fire) begin
      update_vpn_o   = entry_q[lookup_idx].vpn;
      update_asid_o  = entry_q[lookup_idx].asid;
      update_is_4M_o = entry_q[lookup_idx].is_4m;
      update_pte_o   = entry_q[lookup_idx].pte;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    if (!rst_ni) begin
      state_q <= IDLE;
      vaddr_q <= '0;
      itlb_q  <= 1'b0;
      asid_q  <= '0;
      valid_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      itlb_q  <= itlb_d;
      asid_q  <= asid_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
    end
  end

  // NOTE: the entry payload is deliberately not reset; the valid bits alone
  // decide whether an entry is used, so the array can map to plain storage.
  always_ff @(posedge clk_i) begin
    entry_q <= entry_d;
  end

endmodule

// File: tb/tb_shared_tlb_sv32.sv
// ---------------------------------------------------------------------------
// tb_shared_tlb_sv32
//
// Self-checking bench for shared_tlb_sv32. A behavioural model (plain arrays
// of entries plus a pending-request record) predicts every output in every
// cycle. Directed scenarios cover the documented cases, then a randomized
// phase mixes requests, fills, flushes and PTW-busy cycles.
// ---------------------------------------------------------------------------
module tb_shared_tlb_sv32;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [8:0]  asid_i;
  logic        itlb_access_i;
  logic [31:0] itlb_vaddr_i;
  logic        dtlb_access_i;
  logic [31:0] dtlb_vaddr_i;
  logic        itlb_update_valid_o;
  logic        dtlb_update_valid_o;
  logic [19:0] update_vpn_o;
  logic [8:0]  update_asid_o;
  logic        update_is_4M_o;
  logic [31:0] update_pte_o;
  logic        shared_tlb_access_o;
  logic        shared_tlb_hit_o;
  logic [31:0] shared_tlb_vaddr_o;
  logic        itlb_req_o;
  logic        ptw_active_i;
  logic        ptw_update_valid_i;
  logic        ptw_update_is_4M_i;
  logic [19:0] ptw_update_vpn_i;
  logic [8:0]  ptw_update_asid_i;
  logic [31:0] ptw_update_pte_i;

  shared_tlb_sv32 dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .asid_i              (asid_i),
    .itlb_access_i       (itlb_access_i),
    .itlb_vaddr_i        (itlb_vaddr_i),
    .dtlb_access_i       (dtlb_access_i),
    .dtlb_vaddr_i        (dtlb_vaddr_i),
    .itlb_update_valid_o (itlb_update_valid_o),
    .dtlb_update_valid_o (dtlb_update_valid_o),
    .update_vpn_o        (update_vpn_o),
    .update_asid_o       (update_asid_o),
    .update_is_4M_o      (update_is_4M_o),
    .update_pte_o        (update_pte_o),
    .shared_tlb_access_o (shared_tlb_access_o),
    .shared_tlb_hit_o    (shared_tlb_hit_o),
    .shared_tlb_vaddr_o  (shared_tlb_vaddr_o),
    .itlb_req_o          (itlb_req_o),
    .ptw_active_i        (ptw_active_i),
    .ptw_update_valid_i  (ptw_update_valid_i),
    .ptw_update_is_4M_i  (ptw_update_is_4M_i),
    .ptw_update_vpn_i    (ptw_update_vpn_i),
    .ptw_update_asid_i   (ptw_update_asid_i),
    .ptw_update_pte_i    (ptw_update_pte_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------------
  bit          m_valid [8];
  bit          m_4m    [8];
  logic [19:0] m_vpn   [8];
  logic [8:0]  m_asid  [8];
  logic [31:0] m_pte   [8];
  int          m_rr;
  bit          m_pend;
  bit          m_itlb;
  logic [31:0] m_vaddr;
  logic [8:0]  m_lasid;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_rr   = 0;
    m_pend = 1'b0;
  endtask

  // Lowest entry translating va under address space as, or -1.
  function automatic int m_find(input logic [31:0] va, input logic [8:0] as);
    for (int i = 0; i < 8; i++) begin
      if (m_valid[i] && (m_asid[i] == as || m_pte[i][5])) begin
        if (m_4m[i] ? (va[31:22] == m_vpn[i][19:10]) : (va[31:12] == m_vpn[i]))
          return i;
      end
    end
    return -1;
  endfunction

  task automatic m_fill(input logic [19:0] vpn, input logic [8:0] as,
                        input bit is4m, input logic [31:0] pte);
    int slot = -1;
    for (int i = 0; i < 8; i++)
      if (slot < 0 && m_valid[i] && m_vpn[i] == vpn && m_asid[i] == as && m_4m[i] == is4m)
        slot = i;
    for (int i = 0; i < 8; i++)
      if (slot < 0 && !m_valid[i]) slot = i;
    if (slot < 0) begin
      slot = m_rr;
      m_rr = (m_rr + 1) % 8;
    end
    m_valid[slot] = 1'b1;
    m_vpn[slot]   = vpn;
    m_asid[slot]  = as;
    m_4m[slot]    = is4m;
    m_pte[slot]   = pte;
  endtask

  // ------------------------------------------------------------------------
  // One clock cycle: inputs are already driven (just after a falling edge).
  // Check all outputs against the model, then advance the model at the edge.
  // ------------------------------------------------------------------------
  task automatic step();
    int idx;
    bit fire;
    #1;
    fire = m_pend && !flush_i;
    idx  = fire ? m_find(m_vaddr, m_lasid) : -1;
    check("access",   32'(shared_tlb_access_o), 32'(fire));
    check("hit",      32'(shared_tlb_hit_o),    32'(idx >= 0));
    check("vaddr",    shared_tlb_vaddr_o,       fire ? m_vaddr : 32'h0);
    check("itlb_req", 32'(itlb_req_o),          32'(fire && m_itlb));
    check("i_upd",    32'(itlb_update_valid_o), 32'(idx >= 0 && m_itlb));
    check("d_upd",    32'(dtlb_update_valid_o), 32'(idx >= 0 && !m_itlb));
    check("upd_vpn",  32'(update_vpn_o),   (idx >= 0) ? 32'(m_vpn[idx])  : 32'h0);
    check("upd_asid", 32'(update_asid_o),  (idx >= 0) ? 32'(m_asid[idx]) : 32'h0);
    check("upd_4m",   32'(update_is_4M_o), (idx >= 0) ? 32'(m_4m[idx])   : 32'h0);
    check("upd_pte",  update_pte_o,        (idx >= 0) ? m_pte[idx]       : 32'h0);
    @(posedge clk_i);
    if (flush_i) begin
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_pend = 1'b0;
    end else begin
      if (ptw_update_valid_i)
        m_fill(ptw_update_vpn_i, ptw_update_asid_i, ptw_update_is_4M_i, ptw_update_pte_i);
      if (m_pend) begin
        m_pend = 1'b0;
      end else if ((itlb_access_i || dtlb_access_i) && !ptw_active_i) begin
        m_pend  = 1'b1;
        m_itlb  = itlb_access_i;
        m_vaddr = itlb_access_i ? itlb_vaddr_i : dtlb_vaddr_i;
        m_lasid = asid_i;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic idle();
    flush_i            = 1'b0;
    itlb_access_i      = 1'b0;
    dtlb_access_i      = 1'b0;
    itlb_vaddr_i       = '0;
    dtlb_vaddr_i       = '0;
    ptw_active_i       = 1'b0;
    ptw_update_valid_i = 1'b0;
    ptw_update_is_4M_i = 1'b0;
    ptw_update_vpn_i   = '0;
    ptw_update_asid_i  = '0;
    ptw_update_pte_i   = '0;
  endtask

  task automatic fill(input logic [19:0] vpn, input logic [8:0] as,
                      input bit is4m, input logic [31:0] pte);
    idle();
    ptw_update_valid_i = 1'b1;
    ptw_update_vpn_i   = vpn;
    ptw_update_asid_i  = as;
    ptw_update_is_4M_i = is4m;
    ptw_update_pte_i   = pte;
    step();
    idle();
  endtask

  // Request cycle followed by the LOOKUP cycle, where the scenario's own
  // expected hit is checked in addition to the model's full check.
  task automatic lookup(input string tag, input logic [31:0] va, input logic [8:0] as,
                        input bit it, input bit dt, input bit exp_hit);
    idle();
    asid_i        = as;
    itlb_access_i = it;
    dtlb_access_i = dt;
    itlb_vaddr_i  = va;
    dtlb_vaddr_i  = va;
    step();
    idle();
    #1;
    check({tag, "_hit"}, 32'(shared_tlb_hit_o), 32'(exp_hit));
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_access"}, 32'(shared_tlb_access_o), 32'h0);
    check({tag, "_hit"},    32'(shared_tlb_hit_o),    32'h0);
    check({tag, "_vaddr"},  shared_tlb_vaddr_o,       32'h0);
    check({tag, "_ireq"},   32'(itlb_req_o),          32'h0);
    check({tag, "_upd"},    32'({itlb_update_valid_o, dtlb_update_valid_o, update_is_4M_o}), 32'h0);
    check({tag, "_pte"},    update_pte_o,             32'h0);
    check({tag, "_vpn"},    32'({update_asid_o, update_vpn_o}), 32'h0);
  endtask

  logic [19:0] vpn_pool [12];

  initial begin
    idle();
    asid_i = '0;
    rst_ni = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    rst_ni = 1'b1;

    // Empty TLB, ITLB miss.
    idle();
    asid_i = 9'd0;
    itlb_access_i = 1'b1;
    itlb_vaddr_i  = 32'h12345000;
    step();
    idle();
    #1;
    check("s030_access", 32'(shared_tlb_access_o), 32'h1);
    check("s030_hit",    32'(shared_tlb_hit_o),    32'h0);
    check("s030_vaddr",  shared_tlb_vaddr_o,       32'h12345000);
    check("s030_ireq",   32'(itlb_req_o),          32'h1);
    check("s030_iupd",   32'(itlb_update_valid_o), 32'h0);
    step();

    // Nine distinct fills after reset: the ninth lands on entry 0.
    for (int k = 0; k < 9; k++) fill(20'h00100 + 20'(k), 9'd2, 1'b0, 32'h1 + 32'(k << 10));
    lookup("s034_first", 32'h00100000, 9'd2, 1'b0, 1'b1, 1'b0);
    lookup("s034_ninth", 32'h00108000, 9'd2, 1'b0, 1'b1, 1'b1);
    lookup("s034_mid",   32'h00104ABC, 9'd2, 1'b1, 1'b0, 1'b1);

    idle();
    flush_i = 1'b1;
    step();

    // 4K fill then DTLB hit.
    fill(20'h12345, 9'd3, 1'b0, 32'h0ABCD0CF);
    lookup("s031", 32'h12345678, 9'd3, 1'b0, 1'b1, 1'b1);
    check("s031_pte", update_pte_o, 32'h0); // pulse is over one cycle later

    // 4M global mapping hits any ASID; same tag refilled non-global misses.
    fill(20'h40000, 9'd1, 1'b1, 32'h000000EF);
    lookup("s032", 32'h400FF000, 9'd7, 1'b0, 1'b1, 1'b1);
    fill(20'h40000, 9'd1, 1'b1, 32'h000000CF);
    lookup("s033", 32'h400FF000, 9'd7, 1'b0, 1'b1, 1'b0);
    lookup("s033_own", 32'h403FF000, 9'd1, 1'b1, 1'b0, 1'b1);

    // Simultaneous ITLB and DTLB: only the ITLB is served.
    idle();
    asid_i = 9'd3;
    itlb_access_i = 1'b1;
    itlb_vaddr_i  = 32'h77777000;
    dtlb_access_i = 1'b1;
    dtlb_vaddr_i  = 32'h12345000;
    step();
    idle();
    #1;
    check("s035_ireq",  32'(itlb_req_o),         32'h1);
    check("s035_vaddr", shared_tlb_vaddr_o,      32'h77777000);
    step();

    // Request ignored while the PTW is busy.
    idle();
    ptw_active_i  = 1'b1;
    dtlb_access_i = 1'b1;
    dtlb_vaddr_i  = 32'h12345000;
    step();
    idle();
    #1;
    check("busy_access", 32'(shared_tlb_access_o), 32'h0);
    step();

    // Flush in the LOOKUP cycle.
    fill(20'h55555, 9'd0, 1'b0, 32'h0000000F);
    idle();
    asid_i = 9'd0;
    dtlb_access_i = 1'b1;
    dtlb_vaddr_i  = 32'h55555000;
    step();
    idle();
    flush_i = 1'b1;
    #1;
    check("s036_access", 32'(shared_tlb_access_o), 32'h0);
    step();
    lookup("s036_after", 32'h55555000, 9'd0, 1'b0, 1'b1, 1'b0);

    // Reset dropped during LOOKUP.
    fill(20'h0ABCD, 9'd4, 1'b0, 32'h000000FF);
    idle();
    asid_i = 9'd4;
    itlb_access_i = 1'b1;
    itlb_vaddr_i  = 32'h0ABCD000;
    step();
    idle();
    #1;
    check("s037_pre", 32'(shared_tlb_hit_o), 32'h1);
    #1;
    rst_ni = 1'b0;
    #1;
    check_all_zero("s037");
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    lookup("s037_after", 32'h0ABCD000, 9'd4, 1'b1, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 12; i++)
      vpn_pool[i] = {10'(i % 3 + 1), 10'($urandom_range(0, 3))};
    for (int n = 0; n < 3000; n++) begin
      idle();
      asid_i        = 9'($urandom_range(0, 3));
      itlb_access_i = ($urandom_range(0, 99) < 40);
      dtlb_access_i = ($urandom_range(0, 99) < 40);
      itlb_vaddr_i  = {vpn_pool[$urandom_range(0, 11)], 12'($urandom)};
      dtlb_vaddr_i  = {vpn_pool[$urandom_range(0, 11)], 12'($urandom)};
      ptw_active_i  = ($urandom_range(0, 99) < 15);
      flush_i       = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 35) begin
        ptw_update_valid_i = 1'b1;
        ptw_update_vpn_i   = vpn_pool[$urandom_range(0, 11)];
        ptw_update_asid_i  = 9'($urandom_range(0, 3));
        ptw_update_is_4M_i = ($urandom_range(0, 3) == 0);
        ptw_update_pte_i   = $urandom & ~(($urandom_range(0, 3) != 0) ? 32'h20 : 32'h0);
      end
      step();
    end

    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
